// File: rtl/kram_pkg.sv
// kram_pkg: shared slot/bank index types and the slot/PE to bank mapping
package kram_pkg;
  typedef logic [7:0] slot_idx_t;
  typedef logic [7:0] pe_idx_t;
  typedef int unsigned bank_idx_t;
  function automatic bank_idx_t bank_of(input int unsigned slot, input int unsigned pe, input int unsigned pe_num);
    return slot * pe_num + pe;
  endfunction
  function automatic logic in_range(input int unsigned idx, input int unsigned n);
    return idx < n;
  endfunction
endpackage

// File: rtl/kram_rd_pipe.sv
// kram_rd_pipe: DEPTH-stage valid/slot delay line tracking reads in flight
// Ports: in_valid/in_slot (accepted read) -> out_valid/out_slot DEPTH cycles later; rst_n clears all stages.
module kram_rd_pipe import kram_pkg::*; #(
  parameter int DEPTH = 1,
  parameter int SW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [SW-1:0] in_slot,
  output logic          out_valid,
  output logic [SW-1:0] out_slot
);
  logic [DEPTH-1:0] v;
  logic [SW-1:0] s [DEPTH];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < DEPTH; k++) s[k] <= '0;
    end else begin
      v[0] <= in_valid;
      s[0] <= in_slot;
      for (int k = 1; k < DEPTH; k++) begin
        v[k] <= v[k-1];
        s[k] <= s[k-1];
      end
    end
  end
  assign out_valid = v[DEPTH-1];
  assign out_slot = s[DEPTH-1];
endmodule

// File: rtl/kram_xbar.sv
// kram_xbar: crossbar between a SIMD read port, a loader write port and PE_NUM*SLOT_NUM BRAM banks
// Ports: rd_req/rd_slot/rd_addr -> rd_valid/rd_data (read), rd_release/rel_slot (free slot),
//        wr_valid/wr_slot/wr_bank/wr_addr/wr_data/wr_last <-> wr_ready (loader), slot_full, rd_err,
//        bram_addr/bram_wdata/bram_we/bram_en/bram_rdata (banks). rst_n is synchronous active-low.
// Macro KRAM_XBAR_RDBUF_EN adds an output register on rd_valid/rd_data (latency RD_LAT+1).
module kram_xbar import kram_pkg::*; #(
  parameter int PE_NUM = 8,
  parameter int SLOT_NUM = 4,
  parameter int BANK_AW = 10,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rd_req,
  input  logic [$clog2(SLOT_NUM)-1:0]   rd_slot,
  input  logic [BANK_AW-1:0]            rd_addr,
  output logic                          rd_valid,
  output logic [DATA_W-1:0]             rd_data [PE_NUM],
  input  logic                          rd_release,
  input  logic [$clog2(SLOT_NUM)-1:0]   rel_slot,
  input  logic                          wr_valid,
  input  logic [$clog2(SLOT_NUM)-1:0]   wr_slot,
  input  logic [$clog2(PE_NUM)-1:0]     wr_bank,
  input  logic [BANK_AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          wr_last,
  output logic                          wr_ready,
  output logic [SLOT_NUM-1:0]           slot_full,
  output logic                          rd_err,
  output logic [BANK_AW-1:0]            bram_addr [PE_NUM*SLOT_NUM],
  output logic [DATA_W-1:0]             bram_wdata [PE_NUM*SLOT_NUM],
  output logic [PE_NUM*SLOT_NUM-1:0]    bram_we,
  output logic [PE_NUM*SLOT_NUM-1:0]    bram_en,
  input  logic [DATA_W-1:0]             bram_rdata [PE_NUM*SLOT_NUM]
);
  localparam int NB = PE_NUM * SLOT_NUM;
  localparam int SW = $clog2(SLOT_NUM);
  logic rd_acc, wr_fire, p_valid;
  logic [SW-1:0] p_slot;
  logic [DATA_W-1:0] rd_mux [PE_NUM];
  logic [DATA_W-1:0] rd_hold [PE_NUM];
  logic [SLOT_NUM-1:0] full_nx;
  // rst_n gating keeps every bank port quiet while reset is held
  assign rd_acc = rst_n && rd_req && in_range(rd_slot, SLOT_NUM) && slot_full[rd_slot];
  assign wr_ready = in_range(wr_slot, SLOT_NUM) && !slot_full[wr_slot] && !(rd_acc && rd_slot == wr_slot);
  assign wr_fire = rst_n && wr_valid && wr_ready;
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      logic rh, wh;
      rh = rd_acc && (b / PE_NUM) == int'(rd_slot);
      wh = wr_fire && b == int'(bank_of(wr_slot, wr_bank, PE_NUM));
      bram_en[b] = rh || wh;
      bram_we[b] = wh;
      bram_addr[b] = wh ? wr_addr : rh ? rd_addr : '0;
      bram_wdata[b] = wh ? wr_data : '0;
    end
  end
  // a set from the loader wins over a same-cycle release
  always_comb begin
    for (int s = 0; s < SLOT_NUM; s++)
      full_nx[s] = (wr_fire && wr_last && int'(wr_slot) == s) ? 1'b1 :
                   (rd_release && int'(rel_slot) == s) ? 1'b0 : slot_full[s];
  end
  kram_rd_pipe #(.DEPTH(RD_LAT), .SW(SW)) u_pipe (
    .clk(clk), .rst_n(rst_n), .in_valid(rd_acc), .in_slot(rd_slot),
    .out_valid(p_valid), .out_slot(p_slot)
  );
  always_comb begin
    for (int i = 0; i < PE_NUM; i++) begin
      rd_mux[i] = '0;
      for (int s = 0; s < SLOT_NUM; s++) rd_mux[i] = int'(p_slot) == s ? bram_rdata[s*PE_NUM+i] : rd_mux[i];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_full <= '0;
      rd_err <= 1'b0;
      for (int i = 0; i < PE_NUM; i++) rd_hold[i] <= '0;
    end else begin
      slot_full <= full_nx;
      rd_err <= rd_req && !rd_acc;
      if (p_valid) rd_hold <= rd_mux;
    end
  end
`ifdef KRAM_XBAR_RDBUF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) rd_valid <= 1'b0;
    else rd_valid <= p_valid;
  end
  assign rd_data = rd_hold;
`else
  // rd_hold keeps the last response visible while no new one arrives
  assign rd_valid = p_valid;
  always_comb begin
    for (int i = 0; i < PE_NUM; i++) rd_data[i] = p_valid ? rd_mux[i] : rd_hold[i];
  end
`endif
endmodule

// File: doc/kram_xbar.md
KRAM_XBAR -- requirements
Module: kram_xbar

Interface
REQ-001 SHALL have parameter PE_NUM, default 8: number of PEs, equal to banks per slot.
REQ-002 SHALL have parameter SLOT_NUM, default 4: kernel slots; total banks are PE_NUM*SLOT_NUM; slot s owns banks s*PE_NUM..s*PE_NUM+PE_NUM-1.
REQ-003 SHALL have parameter BANK_AW, default 10, and DATA_W, default 8: bank address and data widths.
REQ-004 SHALL have parameter RD_LAT, default 1 (legal 1..3): BRAM read latency in cycles.
REQ-005 SHALL have clk, input, 1: sole clock; all logic on rising edge.
REQ-006 SHALL have rst_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have rd_req, rd_slot[$clog2(SLOT_NUM)], rd_addr[BANK_AW] as inputs: CU SIMD read request, address broadcast to all banks of rd_slot.
REQ-008 SHALL have rd_valid (1) and rd_data[PE_NUM][DATA_W] as outputs: read response, element i from bank i of the slot.
REQ-009 SHALL have rd_release (input, 1) and rel_slot (input, slot width): CU frees a consumed slot.
REQ-010 SHALL have wr_valid, wr_slot, wr_bank[$clog2(PE_NUM)], wr_addr[BANK_AW], wr_data[DATA_W], wr_last as inputs and wr_ready (1) as output: loader write channel, valid/ready handshake.
REQ-011 SHALL have slot_full[SLOT_NUM] (output) as per-slot loaded flags and rd_err (output, 1) as an illegal-read pulse.
REQ-012 SHALL have bram_addr/bram_wdata/bram_we/bram_en arrays (outputs) and bram_rdata array (input), PE_NUM*SLOT_NUM entries each.

Function
REQ-013 SHALL accept a read when rd_req=1, rd_slot<SLOT_NUM and slot_full[rd_slot]=1; the slot's PE_NUM banks get en=1, we=0, addr=rd_addr in that cycle.
REQ-014 SHALL assert rd_valid exactly RD_LAT cycles after an accepted read, with rd_data[i]=bram_rdata[rd_slot*PE_NUM+i] from the slot captured at acceptance; this supports back-to-back reads every cycle.
REQ-015 SHALL hold rd_data at its last value while rd_valid=0.
REQ-016 SHALL reject a read to a non-full or out-of-range slot: no bank enable, no rd_valid, and rd_err=1 for one cycle.
REQ-017 SHALL make a write transfer when wr_valid&&wr_ready; only bank wr_slot*PE_NUM+wr_bank is driven, with en=1, we=1, addr=wr_addr, wdata=wr_data.
REQ-018 SHALL drive wr_ready=0 when slot_full[wr_slot]=1, when wr_slot is out of range, or when an accepted read targets wr_slot in the same cycle (read priority); wr_ready SHALL be 1 otherwise. wr_ready is combinational and SHALL NOT depend on wr_valid.
REQ-019 SHALL set slot_full[wr_slot] on the cycle after a transfer with wr_last=1.
REQ-020 SHALL clear slot_full[rel_slot] on the cycle after rd_release=1; release of a non-full slot has no effect.
REQ-021 SHALL keep a slot full when a set and a clear hit the same slot in the same cycle (set dominates).
REQ-022 SHALL allow a read to slot A and a write to slot B≠A in the same cycle.
REQ-023 SHALL drive all unselected banks with en=0, we=0, addr=0, wdata=0.

Reset
REQ-024 SHALL, with rst_n=0 at a clock edge, clear slot_full, the rd_valid pipeline, rd_data and rd_err to 0; BRAM outputs SHALL be 0 while rst_n=0.
REQ-025 SHALL discard reads in flight when reset occurs: no rd_valid after reset deasserts.

Configuration
REQ-026 SHALL provide macro KRAM_XBAR_RDBUF_EN. When defined, rd_data/rd_valid are re-registered, so total latency is RD_LAT+1. When undefined, latency is RD_LAT. The handshake is otherwise identical in both cases.

Structure
REQ-027 SHALL put slot/bank index typedefs, and the bank_of(slot,pe) helper, in a shared package kram_pkg.
REQ-028 SHALL implement the valid/slot latency pipeline as sub-module kram_rd_pipe (depth RD_LAT); the rest is flat.

Verification
REQ-029 Reset, then a read of slot 0 -> rd_err=1 one cycle, rd_valid stays 0, all bram_en=0.
REQ-030 Write pe0..7 addr 5 slot 1 with data 0x10..0x17, last on pe7 -> slot_full=4'b0010 next cycle; read slot 1 addr 5 -> after RD_LAT cycles, rd_valid=1 and rd_data=0x10..0x17.
REQ-031 Slot 1 full, wr_valid to slot 1 -> wr_ready=0 until rd_release slot 1, then wr_ready=1 next cycle.
REQ-032 Read slot 2 while writing slot 2 in the same cycle -> write stalled one cycle; a concurrent write to slot 3 completes in that cycle.
REQ-033 wr_last to slot 0 and rd_release slot 0 in the same cycle -> slot_full[0]=1.
REQ-034 With KRAM_XBAR_RDBUF_EN and RD_LAT=2: 4 back-to-back reads -> rd_valid high for 4 consecutive cycles starting 3 cycles after the first request; reset asserted mid-stream -> no further rd_valid.
